// File: rtl/apu_sample_scheduler_pkg.sv
// Shared definitions for the APU sample scheduler: sample width, scheduler
// states and the default frame length.
package apu_pkg;

    localparam int AUDIO_W       = 24;
    localparam int FRAME_LEN_DEF = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    function automatic logic [2*AUDIO_W-1:0] pack_pair(
        input logic [AUDIO_W-1:0] left,
        input logic [AUDIO_W-1:0] right
    );
        return {left, right};
    endfunction

endpackage

// File: rtl/apu_sample_scheduler_if.sv
// Sample stream from the decode path and paced parallel data towards the
// I2S transmitter, plus scheduler status.
interface apu_sample_scheduler_if
    import apu_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2
);
    logic [AUDIO_W-1:0]       sample_left;
    logic [AUDIO_W-1:0]       sample_right;
    logic                     sample_valid;
    logic                     sample_ready;
    logic [AUDIO_W-1:0]       pdata_left;
    logic [AUDIO_W-1:0]       pdata_right;
    logic                     pdata_valid;
    logic                     underrun;
    logic                     stream_active;
    logic [FIFO_DEPTH_LOG2:0] fill_level;

    modport master (
        output sample_left, sample_right, sample_valid,
        input  sample_ready, pdata_left, pdata_right, pdata_valid,
        input  underrun, stream_active, fill_level
    );

    modport slave (
        input  sample_left, sample_right, sample_valid,
        output sample_ready, pdata_left, pdata_right, pdata_valid,
        output underrun, stream_active, fill_level
    );
endinterface

// File: rtl/apu_sample_scheduler_fifo.sv
// Synchronous stereo sample FIFO without fall-through; ready is registered
// from the next-state level so a full FIFO is never written.
module apu_sample_fifo
    import apu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 2*AUDIO_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(1 << DEPTH_LOG2);

    logic [WIDTH-1:0]      mem_r [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic [LVL_W-1:0]      level_next_s;
    logic                  ready_r;
    logic                  push_s;
    logic                  pop_s;

    // Qualified push/pop and the next occupancy.
    always_comb begin
        push_s       = push && !full && !flush;
        pop_s        = pop && !empty && !flush;
        level_next_s = level_r;
        if (flush) begin
            level_next_s = '0;
        end else if (push_s && !pop_s) begin
            level_next_s = level_r + LVL_W'(1);
        end else if (pop_s && !push_s) begin
            level_next_s = level_r - LVL_W'(1);
        end else begin
            level_next_s = level_r;
        end
    end

    // Pointers, level and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            ready_r  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
                end
            end
            level_r <= level_next_s;
            ready_r <= (level_next_s != DEPTH_LVL);
        end
    end

    // Storage array; contents are don't-care while empty so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (level_r == DEPTH_LVL);
    assign empty    = (level_r == '0);
    assign ready    = ready_r;
    assign level    = level_r;

endmodule

// File: rtl/apu_sample_scheduler.sv
// Paces buffered stereo samples to the I2S transmitter at one pair per frame,
// with prefill, underrun concealment, stream-loss recovery and mute.
module apu_sample_scheduler
    import apu_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int FRAME_LEN       = FRAME_LEN_DEF,
    parameter int UNDERRUN_LIMIT  = 16
) (
    input  logic MCLK_i,
    input  logic RST_i,
    input  logic ENABLE_i,
    input  logic MUTE_i,
    apu_sample_scheduler_if.slave bus
);
    localparam int PAIR_W = 2*AUDIO_W;
    localparam int LVL_W  = FIFO_DEPTH_LOG2 + 1;
    localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int URUN_W = $clog2(UNDERRUN_LIMIT + 1);
    localparam logic [LVL_W-1:0]  PREFILL_LVL = LVL_W'(1 << (FIFO_DEPTH_LOG2 - 1));
    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(FRAME_LEN - 1);
    localparam logic [URUN_W-1:0] LAST_URUN   = URUN_W'(UNDERRUN_LIMIT - 1);

    state_e              state_r;
    state_e              state_next_s;
    logic [CNT_W-1:0]    frame_cnt_r;
    logic [CNT_W-1:0]    frame_cnt_next_s;
    logic [PAIR_W-1:0]   held_r;
    logic [PAIR_W-1:0]   held_next_s;
    logic [URUN_W-1:0]   urun_cnt_r;
    logic [URUN_W-1:0]   urun_cnt_next_s;
    logic                tick_s;
    logic                pop_s;
    logic                emit_s;
    logic                urun_s;
    logic                push_s;
    logic [PAIR_W-1:0]   fifo_data_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                fifo_ready_s;
    logic [LVL_W-1:0]    fifo_level_s;
    logic [AUDIO_W-1:0]  pdata_left_r;
    logic [AUDIO_W-1:0]  pdata_right_r;
    logic                pdata_valid_r;
    logic                underrun_r;
    logic                stream_active_r;

    assign push_s = bus.sample_valid && fifo_ready_s && !fifo_full_s;

    apu_sample_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (PAIR_W)
    ) u_fifo (
        .clk       (MCLK_i),
        .rst       (RST_i),
        .flush     (!ENABLE_i),
        .push      (push_s),
        .push_data (pack_pair(bus.sample_left, bus.sample_right)),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .ready     (fifo_ready_s),
        .level     (fifo_level_s)
    );

    // Tick decisions: pop/emit/underrun and next state of the scheduler.
    // On stream loss the held pair is kept for that last concealment strobe
    // and replaced by silence on the first PREFILL tick.
    always_comb begin
        tick_s           = (state_r != ST_IDLE) && (frame_cnt_r == LAST_CNT);
        pop_s            = 1'b0;
        emit_s           = 1'b0;
        urun_s           = 1'b0;
        state_next_s     = state_r;
        held_next_s      = held_r;
        urun_cnt_next_s  = urun_cnt_r;
        frame_cnt_next_s = frame_cnt_r;
        if (!ENABLE_i) begin
            state_next_s     = ST_IDLE;
            held_next_s      = '0;
            urun_cnt_next_s  = '0;
            frame_cnt_next_s = '0;
        end else begin
            if (state_r == ST_IDLE) begin
                frame_cnt_next_s = '0;
            end else if (tick_s) begin
                frame_cnt_next_s = '0;
            end else begin
                frame_cnt_next_s = frame_cnt_r + CNT_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (tick_s) begin
                        emit_s = 1'b1;
                        if (fifo_level_s >= PREFILL_LVL) begin
                            pop_s           = 1'b1;
                            held_next_s     = fifo_data_s;
                            urun_cnt_next_s = '0;
                            state_next_s    = ST_RUN;
                        end else begin
                            held_next_s = '0;
                        end
                    end else begin
                        state_next_s = ST_PREFILL;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        emit_s = 1'b1;
                        if (!fifo_empty_s) begin
                            pop_s           = 1'b1;
                            held_next_s     = fifo_data_s;
                            urun_cnt_next_s = '0;
                        end else if (urun_cnt_r == LAST_URUN) begin
                            urun_s          = 1'b1;
                            urun_cnt_next_s = '0;
                            state_next_s    = ST_PREFILL;
                        end else begin
                            urun_s          = 1'b1;
                            urun_cnt_next_s = urun_cnt_r + URUN_W'(1);
                        end
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge MCLK_i) begin
        if (RST_i) begin
            state_r         <= ST_IDLE;
            frame_cnt_r     <= '0;
            held_r          <= '0;
            urun_cnt_r      <= '0;
            pdata_left_r    <= '0;
            pdata_right_r   <= '0;
            pdata_valid_r   <= 1'b0;
            underrun_r      <= 1'b0;
            stream_active_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            frame_cnt_r     <= frame_cnt_next_s;
            held_r          <= held_next_s;
            urun_cnt_r      <= urun_cnt_next_s;
            pdata_left_r    <= MUTE_i ? '0 : held_next_s[PAIR_W-1:AUDIO_W];
            pdata_right_r   <= MUTE_i ? '0 : held_next_s[AUDIO_W-1:0];
            pdata_valid_r   <= emit_s;
            underrun_r      <= urun_s;
            stream_active_r <= (state_next_s == ST_RUN);
        end
    end

    assign bus.sample_ready  = fifo_ready_s;
    assign bus.pdata_left    = pdata_left_r;
    assign bus.pdata_right   = pdata_right_r;
    assign bus.pdata_valid   = pdata_valid_r;
    assign bus.underrun      = underrun_r;
    assign bus.stream_active = stream_active_r;
    assign bus.fill_level    = fifo_level_s;

endmodule

// File: doc/apu_sample_scheduler.md
# apu_sample_scheduler

Paces the APU's audio sample stream into the left-justified I2S transmitter. Upstream logic produces 24-bit stereo samples at an irregular rate; this block buffers them in a small FIFO and issues exactly one sample pair every 512 MCLK cycles (48 kHz at 24.576 MHz). It also handles prefill, underrun concealment, stream-loss detection and muting. It sits between the audio decode path and the serializer's `PDATA_*` inputs.

## Interface
- `FIFO_DEPTH_LOG2`, default 2: FIFO holds 2^N stereo pairs.
- `FRAME_LEN`, default 512: MCLK cycles per output sample pair.
- `UNDERRUN_LIMIT`, default 16: consecutive underruns before the stream is declared lost.
- `MCLK_i` in 1: audio master clock; the only clock.
- `RST_i` in 1: reset, synchronous, active-high.
- `ENABLE_i` in 1: scheduler enable. When low, the block holds IDLE and flushes the FIFO.
- `MUTE_i` in 1: forces emitted data to zero. FIFO pops are unaffected.
- `SAMPLE_LEFT_i` in 24: upstream left sample.
- `SAMPLE_RIGHT_i` in 24: upstream right sample.
- `SAMPLE_VALID_i` in 1: upstream pair valid.
- `SAMPLE_READY_o` out 1: FIFO can accept. A transfer happens when valid and ready are both high.
- `PDATA_LEFT_o` out 24: left sample to the transmitter.
- `PDATA_RIGHT_o` out 24: right sample to the transmitter.
- `PDATA_VALID_o` out 1: one-cycle load strobe to the transmitter.
- `UNDERRUN_o` out 1: one-cycle pulse on each tick where the FIFO was empty while in RUN.
- `STREAM_ACTIVE_o` out 1: high while the state is RUN.
- `FILL_LEVEL_o` out `FIFO_DEPTH_LOG2`+1: current FIFO occupancy.

## Operation
- **Reset values:** all outputs are 0 except `SAMPLE_READY_o`, which is 1. State is IDLE, the frame counter is 0, the FIFO is empty, and the held sample is 0.
- **Frame counter:** counts 0..`FRAME_LEN`-1 and wraps. It runs in PREFILL and RUN and is held at 0 in IDLE. The *tick* is the cycle where the counter equals `FRAME_LEN`-1.
- **States:**
  - IDLE -> PREFILL when `ENABLE_i`=1.
  - PREFILL -> RUN on a tick with fill ≥ 2^(N-1). That tick pops one pair and emits it.
  - RUN, tick, FIFO non-empty: pop the pair, emit it, clear the underrun counter.
  - RUN, tick, FIFO empty: re-emit the held pair, pulse `UNDERRUN_o`, increment the underrun counter.
  - RUN -> PREFILL when the underrun counter reaches `UNDERRUN_LIMIT`. The held pair is cleared to zero.
  - PREFILL, on every tick: emit a zero pair. The transmitter stays triggered and sends silence.
  - Any state -> IDLE when `ENABLE_i`=0. This flushes the FIFO, zeroes the held pair and emits nothing.
- **Emitted data:** `PDATA_*` equal the held pair, or zero while `MUTE_i`=1. Values are registered and stable between strobes.
- **FIFO behaviour:**
  - No fall-through: a sample written on a tick cycle is not visible to that tick's pop.
  - `SAMPLE_READY_o` = !full, registered from the next-state fill level.
  - A push and a pop in the same cycle leave the fill level unchanged.
  - Pointers wrap modulo 2^N.
- **Simultaneous events:** `ENABLE_i` falling on a tick suppresses that tick's strobe. Synchronous reset has priority over everything.

## Timing
- **First strobe:** `PDATA_VALID_o` goes high exactly one cycle after the qualifying tick cycle, with registered data.
- **Strobe spacing:** successive strobes are exactly `FRAME_LEN` cycles apart while in PREFILL or RUN.
- **Start-up:** after reset release with `ENABLE_i`=1 and the FIFO already at prefill level, the first strobe appears at cycle `FRAME_LEN`+1.
- **Status outputs:** `UNDERRUN_o` is coincident with the corresponding `PDATA_VALID_o`. `STREAM_ACTIVE_o` changes on the cycle after the state transition.
- **Ready latency:** `SAMPLE_READY_o` reflects the fill level with one cycle of latency. It never permits a write into a full FIFO.

## Structure
- **Shared package `apu_pkg`:**
  - sample width constant `AUDIO_W`=24
  - state encoding IDLE, PREFILL, RUN
  - default `FRAME_LEN`
- **Sub-module `apu_sample_fifo`:** synchronous stereo FIFO (48-bit word) with push, pop, full, empty and level outputs. The scheduler FSM and frame counter remain in the top module.

## Test plan
- **Basic stream:** enable, push 4 pairs (L=0x000001..0x000004) -> strobes every 512 cycles carrying 1, 2, 3, 4 in order; `STREAM_ACTIVE_o`=1 from the first strobe.
- **Underrun concealment:** after 0x000004 is emitted, stop pushing -> next strobes repeat 0x000004 with `UNDERRUN_o` pulses; pushing 0x000005 restores normal data with no state change.
- **Stream loss:** starve for 16 ticks -> state returns to PREFILL and subsequent strobes carry 0x000000; 2 pushes -> RUN resumes at the next tick.
- **Back-pressure:** push 5 pairs back-to-back with depth 4 -> `SAMPLE_READY_o` drops after the 4th; the 5th is accepted only after the next pop; `FILL_LEVEL_o` never exceeds 4.
- **Mute:** `MUTE_i`=1 during RUN -> data outputs 0, FIFO still drains at one pair per tick; releasing `MUTE_i` shows the current pair.
- **Disable and reset mid-run:** `ENABLE_i`=0 mid-frame -> no further strobes, FIFO level 0. Asserting `RST_i` for 1 cycle mid-frame -> all reset values on the next cycle, `SAMPLE_READY_o`=1.
